// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the default width/latency,
// used by both the ALU and its issue controller so they cannot diverge.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ALU_LAT = 2;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and response valid/ready channels between a requester (master)
// and the ALU issue controller (slave).
interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = 4
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    alu_op_e           cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [TAG_W-1:0]  cmd_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_tag
    );

endinterface

// File: rtl/alu_rsp_fifo.sv
// First-word-fall-through FIFO with occupancy count; the head entry is
// presented on rd_data whenever count is non-zero.
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             full;

    assign rd_ok   = rd_en && (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full && !rd_ok));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue front end for the two-stage ALU: registers commands onto the ALU,
// tracks them through its fixed latency and returns results in issue order.
// Optional ALU_ISSUE_STATS_EN adds saturating issue/stall counters.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_W     = 4,
    parameter int ALU_LAT   = DEF_ALU_LAT,
    parameter int RSP_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus,
    output logic [1:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_stall
`endif
);

    localparam int OCC_W = $clog2(RSP_DEPTH+1);
    localparam int ENT_W = DATA_W + TAG_W;

    logic             issue_p0;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] fifo_cnt;
    logic [ENT_W-1:0] fifo_head;

    logic             trk_vld_p [ALU_LAT+1];
    logic [TAG_W-1:0] trk_tag_p [ALU_LAT+1];

    // Credits cover both in-flight and buffered results, so a result always
    // finds a free FIFO slot even though the ALU cannot be stalled.
    assign bus.cmd_ready = (occ < OCC_W'(RSP_DEPTH));
    assign issue_p0      = bus.cmd_valid && bus.cmd_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign busy          = (occ != '0);

    // Issue stage: operands registered onto the ALU inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else if (issue_p0) begin
            alu_opcode <= bus.cmd_op;
            alu_a      <= bus.cmd_a;
            alu_b      <= bus.cmd_b;
        end
    end

    // Tracking stages: valid/tag follow each op until its result is ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ALU_LAT; i++) begin
                trk_vld_p[i] <= 1'b0;
            end
        end else begin
            trk_vld_p[0] <= issue_p0;
            for (int i = 1; i <= ALU_LAT; i++) begin
                trk_vld_p[i] <= trk_vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        trk_tag_p[0] <= bus.cmd_tag;
        for (int i = 1; i <= ALU_LAT; i++) begin
            trk_tag_p[i] <= trk_tag_p[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({issue_p0, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Response stage: capture result with its tag when the tail is valid
    alu_rsp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (trk_vld_p[ALU_LAT]),
        .wr_data ({alu_result, trk_tag_p[ALU_LAT]}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .count   (fifo_cnt)
    );

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign bus.rsp_valid = (fifo_cnt != '0);
    assign bus.rsp_data  = bus.rsp_valid ? fifo_head[ENT_W-1:TAG_W] : '0;
    assign bus.rsp_tag   = bus.rsp_valid ? fifo_head[TAG_W-1:0]     : '0;

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue_p0 && (stat_issued != 16'hFFFF)) begin
                stat_issued <= stat_issued + 16'd1;
            end
            if (bus.cmd_valid && !bus.cmd_ready && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized and directed bench for alu_issue_ctrl with a behavioural ALU
// and an issue-order scoreboard of expected results and credits.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DW    = 8;
    localparam int TW    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    alu_opcode;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic          busy;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]   stat_issued;
    logic [15:0]   stat_stall;
`endif

    alu_issue_ctrl_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    alu_issue_ctrl #(
        .DATA_W    (DW),
        .TAG_W     (TW),
        .ALU_LAT   (2),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .busy       (busy)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] alu_fn(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            2'b00:   return DW'(a + b);
            2'b01:   return DW'(a - b);
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    // Behavioural two-register ALU (input register + result register)
    logic [1:0]    alu_op_r  = '0;
    logic [DW-1:0] alu_a_r   = '0;
    logic [DW-1:0] alu_b_r   = '0;
    logic [DW-1:0] alu_res_r = '0;
    always @(posedge clk) begin
        alu_op_r  <= alu_opcode;
        alu_a_r   <= alu_a;
        alu_b_r   <= alu_b;
        alu_res_r <= alu_fn(alu_op_r, alu_a_r, alu_b_r);
    end
    assign alu_result = alu_res_r;

    // Scoreboard: expected responses in issue order, each with the cycle it
    // becomes visible; credits are simply accepted minus returned.
    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        int            avail;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   occ_m = 0;
    int   hs_cnt = 0;
    int   pop_cnt = 0;
    int   first_pop = 0;
    int   last_pop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            occ_m = 0;
        end else begin
            logic mv;
            exp_t e;
            mv = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(mv));
            if (mv) begin
                chk("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].d));
                chk("rsp_tag", 32'(bus.rsp_tag), 32'(exp_q[0].t));
            end
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(occ_m < DEPTH));
            chk("busy", 32'(busy), 32'(occ_m != 0));
            if (bus.cmd_valid && bus.cmd_ready) begin
                e.d = alu_fn(bus.cmd_op, bus.cmd_a, bus.cmd_b);
                e.t = bus.cmd_tag;
                e.avail = cyc + 4;
                exp_q.push_back(e);
                occ_m++;
                hs_cnt++;
            end
            if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                occ_m--;
                if (pop_cnt == 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a command and return just after the edge that accepts it.
    task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [TW-1:0] tag, output int waits);
        logic hs;
        bit   done;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = alu_op_e'(op);
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = tag;
        waits = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk);
            hs = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (hs) done = 1;
            else begin
                waits++;
                if (waits > 40) begin
                    chk("issue_timeout", 32'd1, 32'd0);
                    done = 1;
                end
            end
        end
    endtask

    task automatic run_one(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [TW-1:0] tag, input logic [DW-1:0] expd, input string name);
        int w;
        int n;
        issue(op, a, b, tag, w);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            tick(1);
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'd3);
        chk({name, "_data"}, 32'(bus.rsp_data), 32'(expd));
        chk({name, "_tag"}, 32'(bus.rsp_tag), 32'(tag));
        tick(1);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int w;
        int drops;
        int acc;
        logic hs;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ALU_ADD;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b1;
        tick(3);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        run_one(2'b00, 8'h05, 8'h03, 4'h1, 8'h08, "add");
        run_one(2'b01, 8'h00, 8'h01, 4'h2, 8'hFF, "sub");
        run_one(2'b10, 8'hF0, 8'h3C, 4'h3, 8'h30, "and");
        run_one(2'b11, 8'hF0, 8'h0F, 4'h4, 8'hFF, "or");

        // 16 back-to-back commands with responses drained every cycle
        pop_cnt = 0;
        drops = 0;
        for (int i = 0; i < 16; i++) begin
            issue(2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom), TW'(i), w);
            drops += w;
        end
        bus.cmd_valid = 1'b0;
        tick(10);
        chk("b2b_ready_drops", 32'(drops), 32'd0);
        chk("b2b_pop_cnt", 32'(pop_cnt), 32'd16);
        chk("b2b_pop_span", 32'(last_pop - first_pop), 32'd15);

        // Credit limit with the response side stalled
        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = alu_op_e'($urandom_range(0, 3));
            bus.cmd_a     = DW'($urandom);
            bus.cmd_b     = DW'($urandom);
            bus.cmd_tag   = TW'(acc);
            @(negedge clk);
            hs = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (hs) acc++;
        end
        bus.cmd_valid = 1'b0;
        chk("full_accepted", 32'(acc), 32'd8);
        chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        tick(1);
        chk("credit_return", 32'(bus.cmd_ready), 32'd1);
        tick(10);
        chk("full_drained", 32'(busy), 32'd0);

        // Reset with three ops in flight and two buffered
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(2'b11, 8'h5A, 8'hA5, TW'(i + 8), w);
        end
        bus.cmd_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'({bus.rsp_data, bus.rsp_tag}), 32'd0);
        chk("mid_rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        tick(10);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid = ($urandom_range(0, 3) != 0);
            bus.cmd_op    = alu_op_e'($urandom_range(0, 3));
            bus.cmd_a     = DW'($urandom);
            bus.cmd_b     = DW'($urandom);
            bus.cmd_tag   = TW'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick(20);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_busy", 32'(busy), 32'd0);

`ifdef ALU_ISSUE_STATS_EN
        do_reset();
        chk("stat_rst", 32'({stat_issued, stat_stall}), 32'd0);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        tick(13);
        bus.cmd_valid = 1'b0;
        chk("stat_issued", 32'(stat_issued), 32'd8);
        chk("stat_stall", 32'(stat_stall), 32'd5);
        bus.rsp_ready = 1'b1;
        tick(12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
